cic_decimator: RTL
==================

# cic_decimator

Parametrised N-stage CIC decimation filter turning a 1-bit PDM stream into signed PCM samples, all in a single clock domain. Integrators advance on an input-valid strobe. Decimation is done with an internal phase counter rather than a second clock. Combs form an enable-driven pipeline feeding a registered output with a one-cycle valid pulse. It sits between the PDM front end and the audio clock/PCM path.

## Interface
- `N`, default 2: number of integrator and comb stages, 1..5.
- `R`, default 32: decimation ratio, 2..256.
- `OUT_W`, default 16: output sample width, 8..32.
- `clk`  in  1: sole clock; all state changes on its rising edge.
- `reset_n`  in  1: reset, synchronous, active-low.
- `in_valid`  in  1: `pdm` carries a new sample this cycle. May be high every cycle.
- `pdm`  in  1: PDM bit; 1 maps to +1, 0 maps to -1.
- `out_data`  out  OUT_W: signed PCM sample; holds its value between pulses.
- `out_valid`  out  1: one-cycle pulse; `out_data` is new in this cycle.

## Operation
- Internal width `ACC_W = N*clog2(R) + 2`. All integrator, comb and delay registers are ACC_W signed. Arithmetic wraps two's-complement with no saturation, and wrap-around is correct by CIC construction.
- Integrators update only on cycles with `in_valid` = 1:
  - stage 1: `i1 <= i1 + x`, where x = ±1 sign-extended;
  - stage k > 1: `ik <= ik + i(k-1)`, using the pre-edge value of `i(k-1)`.
- Phase counter `ph`, range 0..R-1:
  - increments on each `in_valid`;
  - wraps to 0 after R-1.
  - When `in_valid` is high and `ph` = R-1, that cycle is a decimation strobe.
- Strobe capture: on the edge ending the strobe cycle, the post-update value of `iN` is captured into the comb input register, and `v[0]` is set.
- Comb pipeline: each comb stage k updates only when `v[k-1]` is high.
  - Update: `ck <= in - dk` and `dk <= in`, where `in` is the previous stage's register.
  - `v[k]` is set in the same edge.
- Output stage: when `v[N]` is high, load `out_data` from comb N and pulse `out_valid`.
  - If OUT_W ≤ ACC_W: `out_data` = comb N arithmetically shifted right by ACC_W-OUT_W, i.e. truncation toward -inf.
  - If OUT_W > ACC_W: `out_data` = comb N shifted left by OUT_W-ACC_W, zero-filled.
- Steady-state gain is R^N. The first N output samples after reset are transient; sample N+1 onward is exact.

## Timing
- Reset (`reset_n` = 0 at an edge) clears all of the following:
  - integrators, combs, comb delays;
  - `ph`, the `v[]` flags;
  - `out_data` (to 0) and `out_valid` (to 0).
- Reset applied mid-frame or mid-pipeline discards partial frames and in-flight comb data, and no `out_valid` follows. The first strobe after release is the R-th `in_valid` after release.
- Latency: with the strobe in cycle t, `out_valid` is high in exactly cycle t+N+2, for one cycle.
- The pipeline holds at most one sample per stage. Strobes are at least R ≥ 2 cycles apart, so there is no overlap hazard and no back-pressure; downstream must accept every pulse.
- `in_valid` = 0 cycles freeze the integrators and `ph`. Comb pipeline progress does not depend on `in_valid`.
- A strobe coinciding with `v[N]` from the previous frame is legal; both proceed independently.

## Structure
- Shared package `cic_pkg` holds:
  - a `clog2` function;
  - an `acc_w(N,R)` function;
  - parameter range checks, which are elaboration errors if violated.
- One natural sub-module: `cic_comb_stage`, a single comb stage with enable in, registered result, delay register and valid out, instantiated N times via generate.
- Integrators stay inline as a generate loop over a register array.

## Test plan
- N=2, R=4, OUT_W=16 (ACC_W=6), `pdm` held at 1 with `in_valid` every cycle → from the 3rd pulse on, `out_data` = 16384 (16<<10); pulses every 4 cycles.
- Same configuration, `pdm` held at 0 → steady `out_data` = -16384.
- Same configuration, `pdm` alternating 1,0 every valid → steady `out_data` = 0.
- Latency check: after reset release, `in_valid` every cycle from cycle 0 → strobe at cycle 3, `out_valid` at cycle 7.
- N=3, R=8, `in_valid` every 3rd cycle, `pdm` = 1 → steady output = 512<<(16-11) = 16384; pulse spacing 24 cycles.
- Reset asserted mid-frame (`ph` = 2) and in mid-pipeline (`v[1]` set) → no `out_valid` within N+2 cycles; all outputs 0; the next frame needs R fresh samples.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared constants and elaboration-time helpers for the CIC decimator.
// Provides register sizing and parameter range validation.
package cic_pkg;

    localparam int N_MIN     = 1;
    localparam int N_MAX     = 5;
    localparam int R_MIN     = 2;
    localparam int R_MAX     = 256;
    localparam int OUT_W_MIN = 8;
    localparam int OUT_W_MAX = 32;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int v = value - 1; v > 0; v = v >>> 1) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Bit growth of an N-stage, ratio-R CIC plus sign and one guard bit.
    function automatic int acc_w(input int n, input int r);
        return n * clog2(r) + 2;
    endfunction

    function automatic bit params_ok(input int n, input int r, input int out_w);
        return (n >= N_MIN) && (n <= N_MAX) &&
               (r >= R_MIN) && (r <= R_MAX) &&
               (out_w >= OUT_W_MIN) && (out_w <= OUT_W_MAX);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb stage: y = x - x_delayed, advanced only on an enable pulse.
// Registered result and a valid flag that follows the enable by one cycle.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_en,
    input  logic signed [W-1:0] i_data,
    output logic signed [W-1:0] o_data,
    output logic                o_valid
);

    logic signed [W-1:0] r_data;
    logic signed [W-1:0] r_delay;
    logic                r_valid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_delay <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_en;
            if (i_en) begin
                r_data  <= i_data - r_delay;
                r_delay <= i_data;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator: 1-bit PDM in, signed PCM out every R valid inputs.
// Integrators run on in_valid; a phase counter picks the decimation strobe.
module cic_decimator
    import cic_pkg::*;
#(
    parameter int N     = 2,
    parameter int R     = 32,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic                    pdm,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid
);

    localparam int ACC_W = acc_w(N, R);
    localparam int PH_W  = clog2(R);

    if (!params_ok(N, R, OUT_W)) begin : g_bad_params
        $error("cic_decimator: N, R or OUT_W out of supported range");
    end

    logic signed [ACC_W-1:0] w_x;
    logic signed [ACC_W-1:0] w_integ_next;
    logic                    w_strobe;
    logic [PH_W-1:0]         r_ph;
    logic signed [ACC_W-1:0] r_comb_in;
    logic                    r_v0;
    logic signed [ACC_W-1:0] w_stage_data [N+1];
    logic [N:0]              w_stage_valid;
    logic signed [OUT_W-1:0] w_scaled;
    logic signed [OUT_W-1:0] r_out_data;
    logic                    r_out_valid;

    assign w_x = pdm ? ACC_W'(1) : {ACC_W{1'b1}};

    for (genvar k = 0; k < N; k++) begin : g_integ
        logic signed [ACC_W-1:0] r_acc;
        logic signed [ACC_W-1:0] w_in;

        if (k == 0) begin : g_first
            assign w_in = w_x;
        end else begin : g_next
            assign w_in = g_integ[k-1].r_acc;
        end

        // NOTE: non-blocking updates hand every stage the pre-edge value of its predecessor, which is the cascade recurrence.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_acc <= '0;
            end else if (in_valid) begin
                r_acc <= r_acc + w_in;
            end
        end
    end

    // Value the last integrator takes at this edge, so the strobe frame is complete.
    assign w_integ_next = g_integ[N-1].r_acc + g_integ[N-1].w_in;
    assign w_strobe     = in_valid && (r_ph == PH_W'(R - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ph      <= '0;
            r_comb_in <= '0;
            r_v0      <= 1'b0;
        end else begin
            r_v0 <= w_strobe;
            if (in_valid) begin
                r_ph <= w_strobe ? '0 : r_ph + PH_W'(1);
            end
            if (w_strobe) begin
                r_comb_in <= w_integ_next;
            end
        end
    end

    assign w_stage_data[0]  = r_comb_in;
    assign w_stage_valid[0] = r_v0;

    for (genvar k = 0; k < N; k++) begin : g_comb
        cic_comb_stage #(
            .W (ACC_W)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .i_en    (w_stage_valid[k]),
            .i_data  (w_stage_data[k]),
            .o_data  (w_stage_data[k+1]),
            .o_valid (w_stage_valid[k+1])
        );
    end

    if (OUT_W <= ACC_W) begin : g_shift_right
        assign w_scaled = OUT_W'(w_stage_data[N] >>> (ACC_W - OUT_W));
    end else begin : g_shift_left
        assign w_scaled = {w_stage_data[N], {(OUT_W - ACC_W){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_stage_valid[N];
            if (w_stage_valid[N]) begin
                r_out_data <= w_scaled;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule
